// File: rtl/uart_tx_module.sv
// uart_tx_module: 8N1 UART transmitter fed by a multi-byte-per-clock FIFO.
//   clk      : system clock
//   rstn     : synchronous active-low reset
//   data     : up to N bytes per clock, data[0] is queued (and sent) first
//   push     : number of valid bytes in data this cycle (0..N)
//   can_push : free FIFO slots, capped at N (registered)
//   tx       : serial line, idle high (registered)
//   busy     : frame in progress or FIFO non-empty (registered)
module uart_tx_module #(
   parameter int unsigned clk_mhz  = 50,
   parameter int unsigned boadrate = 9600,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned N        = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [N-1:0][7:0]        data,
   input  logic [$clog2(N+1)-1:0]   push,
   output logic [$clog2(N+1)-1:0]   can_push,
   output logic                     tx,
   output logic                     busy
);

   localparam int unsigned SCALE = clk_mhz * 1000 * 1000 / boadrate;
   localparam int unsigned CW    = $clog2(SCALE) + 1;
   localparam int unsigned PW    = $clog2(N + 1);
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OW    = $clog2(DEPTH + 1);
   localparam int unsigned CAP0  = (N < DEPTH) ? N : DEPTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_d;
   logic            busy_d;
   logic            pop;

   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   rd_q, rd_d;
   logic [AW-1:0]   wr_q, wr_d;
   logic [OW-1:0]   occ_q, occ_d;
   logic [PW-1:0]   can_push_d;
   logic            push_ok;
   int unsigned     occ_n;
   int unsigned     free_n;

   // Serializer next-state: one byte per frame, pops happen on the edge that starts a frame.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (occ_q != '0) begin
               pop     = 1'b1;
               shift_d = mem[rd_q];
               cnt_d   = CW'(SCALE - 1);
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == '0) begin
               tx_d    = shift_q[0];
               cnt_d   = CW'(SCALE - 1);
               bit_d   = 3'd0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               cnt_d = CW'(SCALE - 1);
               if (bit_q != 3'd7) begin
                  // shift_q[1] is the bit that becomes shift_q[0] after this edge
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 3'd1;
                  tx_d    = shift_q[1];
               end else begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == '0) begin
               // Back-to-back frames: start bit begins on the edge ending the stop bit.
               if (occ_q != '0) begin
                  pop     = 1'b1;
                  shift_d = mem[rd_q];
                  cnt_d   = CW'(SCALE - 1);
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // FIFO bookkeeping: all-or-nothing pushes judged against the registered free count.
   always_comb begin
      push_ok    = (push != '0) && (push <= can_push);
      occ_n      = 32'(occ_q) + (push_ok ? 32'(push) : 32'd0) - (pop ? 32'd1 : 32'd0);
      occ_d      = OW'(occ_n);
      free_n     = DEPTH - occ_n;
      can_push_d = PW'((free_n < N) ? free_n : N);
      rd_d       = pop ? AW'((32'(rd_q) + 32'd1) % DEPTH) : rd_q;
      wr_d       = push_ok ? AW'((32'(wr_q) + 32'(push)) % DEPTH) : wr_q;
      busy_d     = (state_d != IDLE) || (occ_d != '0);
   end

   // State and control registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         rd_q     <= '0;
         wr_q     <= '0;
         occ_q    <= '0;
         can_push <= PW'(CAP0);
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx       <= tx_d;
         busy     <= busy_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         occ_q    <= occ_d;
         can_push <= can_push_d;
      end
   end

   // FIFO storage: data[i] lands i slots after the write pointer.
   always_ff @(posedge clk) begin
      if (rstn && push_ok) begin
         for (int i = 0; i < N; i++) begin
            if (PW'(i) < push) begin
               mem[AW'((32'(wr_q) + 32'(i)) % DEPTH)] <= data[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_module.sv
// tb_uart_tx_module: checks uart_tx_module against a frame-level model and a serial decoder.
module tb_uart_tx_module;

   localparam int unsigned CLK_MHZ = 1;
   localparam int unsigned BAUD    = 100000;
   localparam int unsigned SCALE   = 10;
   localparam int unsigned FRAME   = 10 * SCALE;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned N       = 4;
   localparam int unsigned PW      = $clog2(N + 1);

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic [N-1:0][7:0]   data = '0;
   logic [PW-1:0]       push = '0;
   logic [PW-1:0]       can_push;
   logic                tx;
   logic                busy;

   uart_tx_module #(
      .clk_mhz (CLK_MHZ),
      .boadrate(BAUD),
      .DEPTH   (DEPTH),
      .N       (N)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .data    (data),
      .push    (push),
      .can_push(can_push),
      .tx      (tx),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned cycle = 0;

   // Model: FIFO contents plus clocks left in the frame on the wire (0 = line idle).
   logic [7:0]  mq[$];
   int unsigned m_t = 0;
   logic [7:0]  m_cur = '0;
   logic [7:0]  exp_rx[$];

   // Serial decoder state.
   logic        dec_in = 1'b0;
   int unsigned dec_pos = 0;
   logic [7:0]  dec_sh = '0;
   logic        dec_ok = 1'b0;
   logic [7:0]  rx_q[$];

   typedef struct {
      logic              r;
      int                p;
      logic [N-1:0][7:0] d;
      logic              e_tx;
      logic              e_busy;
      int                e_cp;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
      end
   endtask

   function automatic int unsigned model_cap();
      int unsigned free = DEPTH - mq.size();
      return (free < N) ? free : N;
   endfunction

   function automatic logic model_tx();
      int unsigned k;
      if (m_t == 0) return 1'b1;
      k = (FRAME - m_t) / SCALE;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m_cur[k-1];
   endfunction

   task automatic model_edge(input logic r, input int p, input logic [N-1:0][7:0] d);
      int unsigned cap;
      if (!r) begin
         mq.delete();
         m_t = 0;
         return;
      end
      cap = model_cap();
      if (m_t <= 1 && mq.size() > 0) begin
         m_cur = mq.pop_front();
         m_t   = FRAME;
      end else if (m_t > 0) begin
         m_t--;
      end
      if (m_t == 1) exp_rx.push_back(m_cur);
      if (p > 0 && p <= int'(cap)) begin
         for (int i = 0; i < p; i++) mq.push_back(d[i]);
      end
   endtask

   task automatic decode(input logic r);
      int unsigned k;
      if (!r) begin
         dec_in = 1'b0;
         return;
      end
      if (!dec_in) begin
         if (tx !== 1'b0) return;
         dec_in  = 1'b1;
         dec_pos = 0;
         dec_ok  = 1'b1;
      end else begin
         dec_pos++;
      end
      if (dec_pos % SCALE == SCALE / 2) begin
         k = dec_pos / SCALE;
         if (k == 0)      dec_ok = dec_ok & (tx === 1'b0);
         else if (k <= 8) dec_sh[k-1] = tx;
         else             dec_ok = dec_ok & (tx === 1'b1);
      end
      if (dec_pos == FRAME - 1) begin
         dec_in = 1'b0;
         check("rx_framing", 32'(dec_ok), 32'd1);
         rx_q.push_back(dec_sh);
      end
   endtask

   // One clock: drive, take the edge, compare everything against the model.
   task automatic step(input logic r, input int p, input logic [N-1:0][7:0] d);
      rstn = r;
      push = PW'(p);
      data = d;
      @(posedge clk);
      #1;
      cycle++;
      model_edge(r, p, d);
      check("tx", 32'(tx), 32'(model_tx()));
      check("busy", 32'(busy), 32'((m_t > 0) || (mq.size() > 0)));
      check("can_push", 32'(can_push), model_cap());
      decode(r);
   endtask

   task automatic wait_idle(input int unsigned budget);
      int unsigned k = 0;
      while (busy !== 1'b0 && k < budget) begin
         step(1'b1, 0, '0);
         k++;
      end
      if (busy !== 1'b0) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_idle_timeout at cycle %0d: busy=%b after %0d clocks", cycle, busy, k);
      end
   endtask

   task automatic check_last_rx(input string name, input int back, input logic [7:0] exp);
      if (rx_q.size() < back) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: only %0d bytes received, required at least %0d", name, rx_q.size(), back);
      end else begin
         check(name, 32'(rx_q[rx_q.size() - back]), 32'(exp));
      end
   endtask

   initial begin
      int unsigned c_push, c_fall, c_end, k, trans;
      logic        prev_tx;
      int          p;
      logic        r;

      // Reset, idle garbage, one-clock latency, then an overflowing second push.
      tbl.push_back('{1'b0, 0, 32'h0000_0000, 1'b1, 1'b0, 4});
      tbl.push_back('{1'b0, 0, 32'h0000_0000, 1'b1, 1'b0, 4});
      tbl.push_back('{1'b1, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 4});
      tbl.push_back('{1'b1, 1, 32'h0000_00A5, 1'b1, 1'b1, 3});
      tbl.push_back('{1'b1, 0, 32'h0000_0000, 1'b0, 1'b1, 4});
      tbl.push_back('{1'b1, 4, 32'h1312_1110, 1'b0, 1'b1, 0});
      tbl.push_back('{1'b1, 2, 32'h0000_BBAA, 1'b0, 1'b1, 0});
      tbl.push_back('{1'b1, 0, 32'h0000_0000, 1'b0, 1'b1, 0});

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r, tbl[i].p, tbl[i].d);
         check("tbl_tx", 32'(tx), 32'(tbl[i].e_tx));
         check("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
         check("tbl_can_push", 32'(can_push), 32'(tbl[i].e_cp));
      end
      wait_idle(1000);
      check("ovf_can_push_after_drain", 32'(can_push), 32'd4);
      check("ovf_rx_count", rx_q.size(), 32'd5);
      check_last_rx("ovf_byte0", 4, 8'h10);
      check_last_rx("ovf_byte1", 3, 8'h11);
      check_last_rx("ovf_byte2", 2, 8'h12);
      check_last_rx("ovf_byte3", 1, 8'h13);

      // Single byte from idle: latency and frame length.
      step(1'b1, 1, 32'h0000_00A5);
      c_push = cycle;
      k = 0;
      while (tx !== 1'b0 && k < 20) begin step(1'b1, 0, '0); k++; end
      c_fall = cycle;
      while (busy !== 1'b0 && k < 400) begin step(1'b1, 0, '0); k++; end
      c_end = cycle;
      check("a5_latency", c_fall - c_push, 32'd1);
      check("a5_busy_len", c_end - c_fall, FRAME);
      check_last_rx("a5_byte", 1, 8'hA5);

      // Three bytes in one push: contiguous frames in index order.
      step(1'b1, 3, 32'h00FF_8001);
      step(1'b1, 0, '0);
      c_fall = cycle;
      wait_idle(1000);
      check("multi_len", cycle - c_fall, 3 * FRAME);
      check_last_rx("multi_byte0", 3, 8'h01);
      check_last_rx("multi_byte1", 2, 8'h80);
      check_last_rx("multi_byte2", 1, 8'hFF);

      // Reset during data bit 3 of the first of two queued bytes.
      step(1'b1, 2, 32'h0000_6655);
      step(1'b1, 0, '0);
      for (int i = 0; i < 43; i++) step(1'b1, 0, '0);
      step(1'b0, 0, '0);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_can_push", 32'(can_push), 32'd4);
      trans = 0;
      prev_tx = tx;
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 0, '0);
         if (tx !== prev_tx) trans++;
         prev_tx = tx;
      end
      check("rst_no_tx_activity", trans, 32'd0);

      // Idle garbage: push=0 with data present changes nothing.
      for (int i = 0; i < 50; i++) begin
         step(1'b1, 0, 32'hDEAD_BEEF);
         check("garbage_tx", 32'(tx), 32'd1);
         check("garbage_busy", 32'(busy), 32'd0);
         check("garbage_can_push", 32'(can_push), 32'd4);
      end

      // Push in the last clock of the final stop bit.
      step(1'b1, 2, 32'h0000_4281);
      k = 0;
      while (!(m_t == 1 && mq.size() == 0) && k < 400) begin step(1'b1, 0, '0); k++; end
      if (!(m_t == 1 && mq.size() == 0)) begin
         vectors++;
         miscompares++;
         $display("FAIL stop_push_setup_timeout at cycle %0d", cycle);
      end
      step(1'b1, 1, 32'h0000_003C);
      check("stop_push_tx_hi", 32'(tx), 32'd1);
      check("stop_push_busy", 32'(busy), 32'd1);
      step(1'b1, 0, '0);
      check("stop_push_start", 32'(tx), 32'd0);
      wait_idle(400);
      check_last_rx("stop_push_prev", 2, 8'h42);
      check_last_rx("stop_push_byte", 1, 8'h3C);

      // Random traffic with occasional resets.
      for (int i = 0; i < 2500; i++) begin
         r = ($urandom_range(0, 599) != 0);
         p = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, N)) : 0;
         step(r, p, $urandom);
      end
      wait_idle(1000);

      // Everything the model says completed must have been decoded, in order.
      check("rx_total", rx_q.size(), exp_rx.size());
      for (int i = 0; i < rx_q.size() && i < exp_rx.size(); i++) begin
         check("rx_order", 32'(rx_q[i]), 32'(exp_rx[i]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
